// File: rtl/tart_mcb_arbiter_pkg.sv
// Shared configuration for the TART MCB arbiter: FSM encodings, WMAX range
// limits and the grant encoding used by the arbitration function.
package tart_mcb_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CMD  = 1'b1;

    // wcnt is 4 bits wide, so WMAX cannot exceed 15.
    localparam int WMAX_MIN = 1;
    localparam int WMAX_MAX = 15;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    function automatic int wmax_clamp(input int w);
        if (w < WMAX_MIN) return WMAX_MIN;
        if (w > WMAX_MAX) return WMAX_MAX;
        return w;
    endfunction

endpackage

// File: rtl/tart_mcb_arbiter.sv
// Two-client (acquisition write / prefetch read) arbiter in front of an MCB port.
// Define TART_ARB_STATS_EN to build the saturating read-starvation counter on stall_o.
module tart_mcb_arbiter
    import tart_mcb_arbiter_pkg::*;
#(
    parameter int ABITS = 21,
    parameter int DBITS = 32,
    parameter int WMAX  = 4,
    parameter int DELAY = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,

    input  logic             wr_req_i,
    input  logic [ABITS-1:0] wr_adr_i,
    input  logic [DBITS-1:0] wr_dat_i,
    output logic             wr_gnt_o,

    input  logic             rd_req_i,
    input  logic [ABITS-1:0] rd_adr_i,
    output logic             rd_gnt_o,
    output logic             rd_ack_o,
    output logic [DBITS-1:0] rd_dat_o,

    output logic             mcb_ce_o,
    output logic             mcb_wr_o,
    output logic [ABITS-1:0] mcb_adr_o,
    output logic [DBITS-1:0] mcb_dat_o,
    input  logic             mcb_rdy_i,
    input  logic             mcb_ack_i,
    input  logic [DBITS-1:0] mcb_dat_i,

    output logic             busy_o,
    output logic             err_o,
    output logic [15:0]      stall_o
);

    localparam logic [3:0] WCAP = 4'(wmax_clamp(WMAX));

    // DELAY only shaped simulation timing in the original design; it has no hardware effect.
    logic unused_delay;
    assign unused_delay = ^DELAY;

    logic [0:0]       state_q,   state_d;
    logic [3:0]       wcnt_q,    wcnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             err_q,     err_d;
    logic             wr_gnt_q,  wr_gnt_d;
    logic             rd_gnt_q,  rd_gnt_d;
    logic             rd_ack_q,  rd_ack_d;
    logic [DBITS-1:0] rd_dat_q,  rd_dat_d;
    logic             mcb_wr_q,  mcb_wr_d;
    logic [ABITS-1:0] mcb_adr_q, mcb_adr_d;
    logic [DBITS-1:0] mcb_dat_q, mcb_dat_d;
    gnt_e             gnt;

    // Writes win unless a read can go and the write burst has reached its cap.
    function automatic gnt_e arbitrate(input logic rdy, input logic wr_req,
                                       input logic rd_ok, input logic [3:0] wcnt);
        if (!rdy) return GNT_NONE;
        if (rd_ok && (!wr_req || wcnt == WCAP)) return GNT_RD;
        if (wr_req) return GNT_WR;
        return GNT_NONE;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
        gnt       = GNT_NONE;
        state_d   = ST_IDLE;
        wcnt_d    = wcnt_q;
        rd_pend_d = rd_pend_q;
        err_d     = err_q;
        wr_gnt_d  = 1'b0;
        rd_gnt_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rd_dat_d  = rd_dat_q;
        mcb_wr_d  = mcb_wr_q;
        mcb_adr_d = mcb_adr_q;
        mcb_dat_d = mcb_dat_q;

        if (state_q == ST_IDLE) begin
            gnt = arbitrate(mcb_rdy_i, wr_req_i, rd_req_i & ~rd_pend_q, wcnt_q);
            if (!wr_req_i) wcnt_d = '0;
            case (gnt)
                GNT_WR: begin
                    state_d   = ST_CMD;
                    wr_gnt_d  = 1'b1;
                    mcb_wr_d  = 1'b1;
                    mcb_adr_d = wr_adr_i;
                    mcb_dat_d = wr_dat_i;
                    // Held at the cap while a read is outstanding so the read wins once it clears.
                    if (wcnt_q != WCAP) wcnt_d = wcnt_q + 4'd1;
                end
                GNT_RD: begin
                    state_d   = ST_CMD;
                    rd_gnt_d  = 1'b1;
                    mcb_wr_d  = 1'b0;
                    mcb_adr_d = rd_adr_i;
                    wcnt_d    = '0;
                    rd_pend_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (mcb_ack_i) begin
            rd_dat_d = mcb_dat_i;
            if (rd_pend_q) begin
                rd_ack_d  = 1'b1;
                rd_pend_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_i) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            wr_gnt_q  <= 1'b0;
            rd_gnt_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_dat_q  <= '0;
            mcb_wr_q  <= 1'b0;
            mcb_adr_q <= '0;
            mcb_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            wr_gnt_q  <= wr_gnt_d;
            rd_gnt_q  <= rd_gnt_d;
            rd_ack_q  <= rd_ack_d;
            rd_dat_q  <= rd_dat_d;
            mcb_wr_q  <= mcb_wr_d;
            mcb_adr_q <= mcb_adr_d;
            mcb_dat_q <= mcb_dat_d;
        end
    end

`ifdef TART_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (rd_req_i && !rd_gnt_q && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign stall_o = stall_q;
`else
    assign stall_o = '0;
`endif

    assign mcb_ce_o  = (state_q == ST_CMD);
    assign mcb_wr_o  = mcb_wr_q;
    assign mcb_adr_o = mcb_adr_q;
    assign mcb_dat_o = mcb_dat_q;
    assign wr_gnt_o  = wr_gnt_q;
    assign rd_gnt_o  = rd_gnt_q;
    assign rd_ack_o  = rd_ack_q;
    assign rd_dat_o  = rd_dat_q;
    assign busy_o    = mcb_ce_o | rd_pend_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_tart_mcb_arbiter.sv
// Scoreboard bench for tart_mcb_arbiter: expected MCB commands and read data are
// queued as stimulus is driven and popped when the DUT issues them.
module tb_tart_mcb_arbiter;

    localparam int ABITS = 21;
    localparam int DBITS = 32;

    typedef struct packed {
        logic             wr;
        logic [ABITS-1:0] adr;
        logic [DBITS-1:0] dat;
    } cmd_t;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             wr_req_i = 1'b0;
    logic [ABITS-1:0] wr_adr_i = '0;
    logic [DBITS-1:0] wr_dat_i = '0;
    logic             wr_gnt_o;
    logic             rd_req_i = 1'b0;
    logic [ABITS-1:0] rd_adr_i = '0;
    logic             rd_gnt_o;
    logic             rd_ack_o;
    logic [DBITS-1:0] rd_dat_o;
    logic             mcb_ce_o;
    logic             mcb_wr_o;
    logic [ABITS-1:0] mcb_adr_o;
    logic [DBITS-1:0] mcb_dat_o;
    logic             mcb_rdy_i = 1'b1;
    logic             mcb_ack_i = 1'b0;
    logic [DBITS-1:0] mcb_dat_i = '0;
    logic             busy_o;
    logic             err_o;
    logic [15:0]      stall_o;

    int   n_total = 0;
    int   n_bad   = 0;
    int   n_cmd   = 0;
    cmd_t cmd_q[$];
    logic [DBITS-1:0] rd_q[$];
    cmd_t mon_e;
    logic [DBITS-1:0] mon_d;

    tart_mcb_arbiter dut (
        .clock_i   (clk),
        .reset_i   (reset_i),
        .wr_req_i  (wr_req_i),
        .wr_adr_i  (wr_adr_i),
        .wr_dat_i  (wr_dat_i),
        .wr_gnt_o  (wr_gnt_o),
        .rd_req_i  (rd_req_i),
        .rd_adr_i  (rd_adr_i),
        .rd_gnt_o  (rd_gnt_o),
        .rd_ack_o  (rd_ack_o),
        .rd_dat_o  (rd_dat_o),
        .mcb_ce_o  (mcb_ce_o),
        .mcb_wr_o  (mcb_wr_o),
        .mcb_adr_o (mcb_adr_o),
        .mcb_dat_o (mcb_dat_o),
        .mcb_rdy_i (mcb_rdy_i),
        .mcb_ack_i (mcb_ack_i),
        .mcb_dat_i (mcb_dat_i),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [ABITS-1:0] adr, input logic [DBITS-1:0] dat);
        cmd_t c;
        c.wr  = wr;
        c.adr = adr;
        c.dat = dat;
        cmd_q.push_back(c);
    endtask

    task automatic wait_cmds(input int target, input int budget);
        int k = 0;
        while (n_cmd < target && k < budget) begin
            step();
            k++;
        end
        check("wait_cmd_count", n_cmd, target);
    endtask

    // Scoreboard side: commands and read returns are compared as the DUT produces them.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (mcb_ce_o) begin
                n_cmd++;
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd", mcb_ce_o, 0);
                end else begin
                    mon_e = cmd_q.pop_front();
                    check("cmd_wr", mcb_wr_o, mon_e.wr);
                    check("cmd_adr", mcb_adr_o, mon_e.adr);
                    if (mon_e.wr) check("cmd_dat", mcb_dat_o, mon_e.dat);
                    check("cmd_wr_gnt", wr_gnt_o, mon_e.wr);
                    check("cmd_rd_gnt", rd_gnt_o, !mon_e.wr);
                end
            end else if (wr_gnt_o || rd_gnt_o) begin
                check("gnt_without_ce", {wr_gnt_o, rd_gnt_o}, 0);
            end
            if (rd_ack_o) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rd_ack", rd_ack_o, 0);
                end else begin
                    mon_d = rd_q.pop_front();
                    check("rd_dat", rd_dat_o, mon_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        repeat (3) step();
        check("rst_ce", mcb_ce_o, 0);
        check("rst_wr", mcb_wr_o, 0);
        check("rst_wr_gnt", wr_gnt_o, 0);
        check("rst_rd_gnt", rd_gnt_o, 0);
        check("rst_rd_ack", rd_ack_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_adr", mcb_adr_o, 0);
        check("rst_dat", mcb_dat_o, 0);
        check("rst_rd_dat", rd_dat_o, 0);
        reset_i = 1'b0;
        step();

        // Single write, one-cycle grant latency.
        wr_req_i = 1'b1;
        wr_adr_i = 21'h00010;
        wr_dat_i = 32'h00ABCDEF;
        push_cmd(1'b1, 21'h00010, 32'h00ABCDEF);
        step();
        check("w1_ce", mcb_ce_o, 1);
        check("w1_wr_gnt", wr_gnt_o, 1);
        wr_req_i = 1'b0;
        step();
        check("w1_ce_pulse", mcb_ce_o, 0);
        check("w1_gnt_pulse", wr_gnt_o, 0);
        step();

        // Write burst capped at WMAX=4, then one read, then writes resume.
        base = n_cmd;
        wr_req_i = 1'b1;
        wr_adr_i = 21'h00020;
        wr_dat_i = 32'h00000011;
        rd_req_i = 1'b1;
        rd_adr_i = 21'h00030;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 21'h00020, 32'h00000011);
        push_cmd(1'b0, 21'h00030, '0);
        for (int i = 0; i < 2; i++) push_cmd(1'b1, 21'h00020, 32'h00000011);
        wait_cmds(base + 7, 40);
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        step();
        check("wmax_busy_pending", busy_o, 1);
        mcb_ack_i = 1'b1;
        mcb_dat_i = 32'hCAFEF00D;
        rd_q.push_back(32'hCAFEF00D);
        step();
        mcb_ack_i = 1'b0;
        check("wmax_rd_ack", rd_ack_o, 1);
        step();
        check("wmax_idle_busy", busy_o, 0);

        // One outstanding read: no second read until the late ack arrives.
        base = n_cmd;
        rd_req_i = 1'b1;
        rd_adr_i = 21'h1FFFFF;
        push_cmd(1'b0, 21'h1FFFFF, '0);
        wait_cmds(base + 1, 10);
        repeat (7) step();
        check("pend_no_second_read", n_cmd, base + 1);
        check("pend_busy", busy_o, 1);
        mcb_ack_i = 1'b1;
        mcb_dat_i = 32'h12345678;
        rd_req_i  = 1'b0;
        rd_q.push_back(32'h12345678);
        step();
        mcb_ack_i = 1'b0;
        mcb_dat_i = 32'hFFFF0000;
        check("pend_rd_ack", rd_ack_o, 1);
        check("pend_rd_dat", rd_dat_o, 32'h12345678);
        step();
        check("pend_rd_ack_pulse", rd_ack_o, 0);
        check("pend_rd_dat_hold", rd_dat_o, 32'h12345678);
        check("pend_busy_clear", busy_o, 0);

        // MCB not ready: nothing issues until mcb_rdy_i rises.
        mcb_rdy_i = 1'b0;
        wr_req_i  = 1'b1;
        wr_adr_i  = 21'h00040;
        wr_dat_i  = 32'h000055AA;
        rd_req_i  = 1'b1;
        rd_adr_i  = 21'h00044;
        for (int i = 0; i < 10; i++) begin
            step();
            check("nrdy_ce_low", mcb_ce_o, 0);
        end
        push_cmd(1'b1, 21'h00040, 32'h000055AA);
        mcb_rdy_i = 1'b1;
        step();
        check("nrdy_first_ce", mcb_ce_o, 1);
        check("nrdy_first_wr_gnt", wr_gnt_o, 1);
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
`ifdef TART_ARB_STATS_EN
        check("nrdy_stall_ge10", stall_o >= 16'd10, 1);
`else
        check("nrdy_stall_tied", stall_o, 0);
`endif
        step();
        step();

        // Reset abandons a pending read; the stale ack is an error, not a return.
        base = n_cmd;
        rd_req_i = 1'b1;
        rd_adr_i = 21'h00055;
        push_cmd(1'b0, 21'h00055, '0);
        wait_cmds(base + 1, 10);
        rd_req_i = 1'b0;
        step();
        check("rst_mid_busy_before", busy_o, 1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_err", err_o, 0);
        mcb_ack_i = 1'b1;
        mcb_dat_i = 32'h0000DEAD;
        step();
        mcb_ack_i = 1'b0;
        check("stale_ack_err", err_o, 1);
        check("stale_ack_rd_ack", rd_ack_o, 0);
        check("stale_ack_busy", busy_o, 0);
        step();
        check("stale_err_sticky", err_o, 1);
        check("stale_no_rd_ack", rd_ack_o, 0);

        check("sb_cmd_empty", cmd_q.size(), 0);
        check("sb_rd_empty", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tart_mcb_arbiter.md
TART_MCB_ARBITER -- requirements
Module: tart_mcb_arbiter

Interface
REQ-001 SHALL have parameter ABITS, default 21, meaning MCB word-address width.
REQ-002 SHALL have parameter DBITS, default 32, meaning MCB data width.
REQ-003 SHALL have parameter WMAX, default 4, meaning maximum consecutive write grants while a read waits; legal range 1..15.
REQ-004 SHALL have parameter DELAY, default 3, meaning simulation-only assignment delay.
REQ-005 SHALL have port clock_i, input, 1 bit: the single system/Wishbone clock; reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_req_i, input, 1 bit: acquisition write request (level).
REQ-007 SHALL have ports wr_adr_i, input, ABITS bits, and wr_dat_i, input, DBITS bits: write address and data.
REQ-008 SHALL have port wr_gnt_o, output, 1 bit: write accepted (one-cycle pulse).
REQ-009 SHALL have port rd_req_i, input, 1 bit: prefetch read request (level).
REQ-010 SHALL have port rd_adr_i, input, ABITS bits: read address.
REQ-011 SHALL have port rd_gnt_o, output, 1 bit: read accepted (one-cycle pulse).
REQ-012 SHALL have ports rd_ack_o, output, 1 bit, and rd_dat_o, output, DBITS bits: read data valid and read data.
REQ-013 SHALL have ports mcb_ce_o, output, 1 bit, and mcb_wr_o, output, 1 bit: MCB command strobe and write select.
REQ-014 SHALL have ports mcb_adr_o, output, ABITS bits, and mcb_dat_o, output, DBITS bits: MCB command address and write data.
REQ-015 SHALL have ports mcb_rdy_i, input, 1 bit: MCB ready; mcb_ack_i, input, 1 bit: read data valid; mcb_dat_i, input, DBITS bits: read data.
REQ-016 SHALL have ports busy_o, output, 1 bit: command in flight or read pending; err_o, output, 1 bit: sticky protocol error.
REQ-017 SHALL have port stall_o, output, 16 bits: read-starvation cycle count.

Function
REQ-018 SHALL implement FSM states IDLE and CMD.
REQ-019 SHALL leave IDLE for CMD only when mcb_rdy_i=1 and at least one request is grantable.
REQ-020 SHALL always return from CMD to IDLE after exactly one cycle, so issued commands are spaced at least 2 cycles apart.
REQ-021 SHALL, on the IDLE->CMD edge, register mcb_adr_o, mcb_dat_o and mcb_wr_o from the winner and pulse the winner's gnt.
REQ-022 SHALL assert mcb_ce_o for exactly the CMD cycle, coincident with the gnt pulse.
REQ-023 SHALL treat a read as grantable only when rd_req_i=1 and rd_pend=0: one outstanding read maximum.
REQ-024 SHALL treat writes as grantable regardless of rd_pend.
REQ-025 SHALL give writes priority, except when a read is grantable and wcnt==WMAX, in which case the read wins.
REQ-026 SHALL increment the 4-bit wcnt on each write grant and clear it on a read grant or when wr_req_i=0 in IDLE.
REQ-027 SHALL set rd_pend on read grant and clear it on mcb_ack_i.
REQ-028 SHALL, when mcb_ack_i=1, register rd_dat_o from mcb_dat_i and pulse rd_ack_o on the next cycle (latency 1).
REQ-029 SHALL let rd_dat_o hold its value otherwise.
REQ-030 SHALL set err_o when mcb_ack_i=1 while rd_pend=0; err_o holds until reset.
REQ-031 SHALL, if read grant and mcb_ack_i for the prior read coincide, not reach that case: a new read is never granted while rd_pend=1.
REQ-032 SHALL make busy_o = (state==CMD) | rd_pend.
REQ-033 SHALL hold mcb_adr_o, mcb_dat_o and mcb_wr_o stable outside CMD; they are don't-care when mcb_ce_o=0.

Reset
REQ-034 SHALL, on reset_i=1 at a clock edge, set state=IDLE, rd_pend=0, wcnt=0, err_o=0, and set mcb_ce_o, mcb_wr_o, wr_gnt_o, rd_gnt_o and rd_ack_o to 0.
REQ-035 SHALL reset stall_o to 0, and mcb_adr_o, mcb_dat_o and rd_dat_o to 0.
REQ-036 SHALL abandon a pending read on reset mid-operation; a stale mcb_ack_i after reset sets err_o and produces no rd_ack_o.

Configuration
REQ-037 SHALL, with macro TART_ARB_STATS_EN defined, increment stall_o each cycle rd_req_i=1 and rd_gnt_o=0, saturating at 16'hFFFF.
REQ-038 SHALL, without TART_ARB_STATS_EN, tie stall_o to 0 and generate no counter logic.

Structure
REQ-039 SHALL place the FSM state encodings (IDLE=1'b0, CMD=1'b1) and the WMAX range limit in the shared tartcfg configuration include.
REQ-040 SHALL contain no sub-modules; the grant/priority logic is a single combinational function within the block.

Verification
REQ-041 SHALL verify: mcb_rdy_i=1, wr_req_i=1 with wr_adr_i=21'h00010 and wr_dat_i=32'h00ABCDEF -> mcb_ce_o=1, mcb_wr_o=1, mcb_adr_o=21'h00010, mcb_dat_o=32'h00ABCDEF, and wr_gnt_o=1 one cycle after the request is sampled.
REQ-042 SHALL verify: wr_req_i and rd_req_i held high continuously with WMAX=4 -> 4 write grants, then 1 read grant, then writes resume.
REQ-043 SHALL verify: read at rd_adr_i=21'h1FFFFF granted, rd_req_i kept high, mcb_ack_i after 7 cycles with mcb_dat_i=32'h12345678 -> no second read before the ack; rd_ack_o=1 and rd_dat_o=32'h12345678 one cycle after the ack.
REQ-044 SHALL verify: mcb_rdy_i=0 for 10 cycles with both requests high -> mcb_ce_o stays 0; the first command follows mcb_rdy_i rising; with TART_ARB_STATS_EN defined, stall_o=10 or more.
REQ-045 SHALL verify: reset_i pulsed while rd_pend=1, then mcb_ack_i=1 -> err_o=1, rd_ack_o=0, busy_o=0.
